io_port_write_strobe: RTL and testbench

//  S-100 output-cycle decoder feeding the n-bit output-port latch stage.

---
 rtl/io_port_write_strobe.sv | 148 ++++++++++++++
 tb/tb_io_port_write_strobe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_write_strobe.sv
// ----------------------------------------------------------------------------
// io_port_write_strobe
//   Output-cycle decoder for an S-100 style bus. Synchronises the bus write
//   strobe (pwr_n) and output-cycle status (s_out), matches the port address,
//   captures the data byte, holds the bus with wait states, then issues a
//   single one-clock load pulse to the downstream output-port latch. That
//   latch samples on the falling clock edge, so a full-cycle load pulse puts
//   the latch's sampling edge in the middle of the pulse.
//
// Ports
//   clock       in   1       system clock, all logic on posedge
//   reset       in   1       synchronous, active-high
//   s_out       in   1       bus status: output cycle (asynchronous)
//   pwr_n       in   1       bus write strobe, active low (asynchronous)
//   addr        in   ADDR_W  bus port address, stable while pwr_n low
//   dout_bus    in   DATA_W  bus data-out, stable while pwr_n low
//   load        out  1       one-clock latch load pulse
//   latch_data  out  DATA_W  captured byte for the latch
//   rdy         out  1       bus ready, 0 inserts a wait state
//   busy        out  1       sequencer not idle
//   wr_count    out  8       number of load pulses issued, wraps at 256
// ----------------------------------------------------------------------------
// state     | meaning
// ST_IDLE   | waiting for a strobe falling edge addressed to this port
// ST_WAIT   | byte captured, rdy held low for WAIT_CYCLES clocks
// ST_STROBE | load pulse is on the output this cycle
// ST_HOLD   | waiting for the bus strobe to return high
// ----------------------------------------------------------------------------
module io_port_write_strobe #(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter logic [ADDR_W-1:0] PORT_ADDR   = 8'h6C,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s_out,
    input  logic              pwr_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dout_bus,
    output logic              load,
    output logic [DATA_W-1:0] latch_data,
    output logic              rdy,
    output logic              busy,
    output logic [7:0]        wr_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STROBE,
        ST_HOLD
    } state_t;

    // Counter preload: the WAIT state is occupied for WAIT_CYCLES clocks and
    // leaves when the counter reaches zero, so it starts at WAIT_CYCLES-1.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t     state;
    logic [3:0] wait_cnt;

    logic pwr_s1, pwr_s2, pwr_prev;
    logic sout_s1, sout_s2;
    logic wr_fall;
    logic hit;

    // Falling edge of the synchronised strobe; pwr_prev is one stage behind
    // pwr_s2 so each bus cycle produces exactly one wr_fall.
    assign wr_fall = pwr_prev & ~pwr_s2;

    // Address and data are taken raw: the bus holds them stable while pwr_n
    // is low, which covers the synchroniser latency.
    assign hit = wr_fall & sout_s2 & (addr == PORT_ADDR);

    always_ff @(posedge clock) begin
        if (reset) begin
            pwr_s1     <= 1'b1;
            pwr_s2     <= 1'b1;
            pwr_prev   <= 1'b1;
            sout_s1    <= 1'b0;
            sout_s2    <= 1'b0;
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            load       <= 1'b0;
            rdy        <= 1'b1;
            busy       <= 1'b0;
            latch_data <= '0;
            wr_count   <= 8'd0;
        end else begin
            pwr_s1   <= pwr_n;
            pwr_s2   <= pwr_s1;
            pwr_prev <= pwr_s2;
            sout_s1  <= s_out;
            sout_s2  <= sout_s1;

            load <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        latch_data <= dout_bus;
                        busy       <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state    <= ST_STROBE;
                            load     <= 1'b1;
                            wr_count <= wr_count + 8'd1;
                        end else begin
                            state    <= ST_WAIT;
                            rdy      <= 1'b0;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end

                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state    <= ST_STROBE;
                        rdy      <= 1'b1;
                        load     <= 1'b1;
                        wr_count <= wr_count + 8'd1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                ST_STROBE: begin
                    state <= ST_HOLD;
                end

                ST_HOLD: begin
                    // A strobe that already rose during WAIT lets this exit
                    // on the first HOLD cycle.
                    if (pwr_s2) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    rdy   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_write_strobe.sv
module tb_io_port_write_strobe;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       s_out = 1'b0;
    logic       pwr_n = 1'b1;
    logic [7:0] addr  = 8'h00;
    logic [7:0] dout_bus = 8'h00;

    // index 0: WAIT_CYCLES=2 build, index 1: WAIT_CYCLES=0 build
    logic [1:0] load_o, rdy_o, busy_o;
    logic [7:0] data_o [2];
    logic [7:0] cnt_o  [2];

    always #5 clock = ~clock;

    io_port_write_strobe #(.WAIT_CYCLES(2)) u_dut_w2 (
        .clock(clock), .reset(reset), .s_out(s_out), .pwr_n(pwr_n),
        .addr(addr), .dout_bus(dout_bus), .load(load_o[0]),
        .latch_data(data_o[0]), .rdy(rdy_o[0]), .busy(busy_o[0]),
        .wr_count(cnt_o[0])
    );

    io_port_write_strobe #(.WAIT_CYCLES(0)) u_dut_w0 (
        .clock(clock), .reset(reset), .s_out(s_out), .pwr_n(pwr_n),
        .addr(addr), .dout_bus(dout_bus), .load(load_o[1]),
        .latch_data(data_o[1]), .rdy(rdy_o[1]), .busy(busy_o[1]),
        .wr_count(cnt_o[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    // ------------------------------------------------------------------
    // Reference model: timestamp based. Raw pwr_n/s_out samples are kept
    // as a short history; a hit at edge e0 implies rdy low after edges
    // e0..e0+W-1, load after edge e0+W, and release once the strobe seen
    // through the synchroniser is high at an edge >= e0+W+2.
    // ------------------------------------------------------------------
    int         edge_n = 0;
    bit         model_ok = 0;
    logic       ph1, ph2, ph3, sh1, sh2;
    logic       m_fall, m_hit;
    bit         m_active [2];
    int         m_e0     [2];
    logic [7:0] m_data   [2];
    logic [7:0] m_cnt    [2];
    logic       m_load   [2];
    logic       m_rdy    [2];
    logic       m_busy   [2];

    function automatic int wc(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    always @(posedge clock) begin
        edge_n = edge_n + 1;
        if (reset) begin
            ph1 = 1'b1; ph2 = 1'b1; ph3 = 1'b1; sh1 = 1'b0; sh2 = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_active[i] = 0; m_e0[i] = 0; m_data[i] = 8'h00; m_cnt[i] = 8'h00;
                m_load[i] = 1'b0; m_rdy[i] = 1'b1; m_busy[i] = 1'b0;
            end
            model_ok = 1;
        end else begin
            m_fall = ph3 & ~ph2;
            m_hit  = m_fall & sh2 & (addr == 8'h6C);
            for (int i = 0; i < 2; i++) begin
                if (!m_active[i]) begin
                    if (m_hit) begin
                        m_active[i] = 1; m_e0[i] = edge_n; m_data[i] = dout_bus;
                    end
                end else if (edge_n >= m_e0[i] + wc(i) + 2 && ph2) begin
                    m_active[i] = 0;
                end
                m_load[i] = m_active[i] && (edge_n == m_e0[i] + wc(i));
                if (m_load[i]) m_cnt[i] = m_cnt[i] + 8'd1;
                m_busy[i] = m_active[i];
                m_rdy[i]  = !(m_active[i] && (edge_n - m_e0[i] < wc(i)));
            end
            ph3 = ph2; ph2 = ph1; ph1 = pwr_n;
            sh2 = sh1; sh1 = s_out;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    int loads  [2];
    int rdylow [2];

    task automatic monitor_loop();
        forever begin
            @(negedge clock);
            if (model_ok) begin
                for (int i = 0; i < 2; i++) begin
                    chk(i == 0 ? "w2_outputs" : "w0_outputs",
                        {13'd0, load_o[i], rdy_o[i], busy_o[i], data_o[i], cnt_o[i]},
                        {13'd0, m_load[i], m_rdy[i], m_busy[i], m_data[i], m_cnt[i]});
                    if (load_o[i]) loads[i] = loads[i] + 1;
                    if (!rdy_o[i]) rdylow[i] = rdylow[i] + 1;
                end
            end
        end
    endtask

    task automatic clear_counts();
        @(negedge clock); #1;
        for (int i = 0; i < 2; i++) begin loads[i] = 0; rdylow[i] = 0; end
    endtask

    task automatic do_write(input logic [7:0] a, input logic so, input logic [7:0] d,
                            input int low_len, input int high_len);
        @(negedge clock);
        addr = a; dout_bus = d; s_out = so;
        @(negedge clock);
        pwr_n = 1'b0;
        repeat (low_len) @(negedge clock);
        pwr_n = 1'b1;
        repeat (high_len) @(negedge clock);
        #1;
    endtask

    typedef struct {
        logic [7:0] a;
        logic       so;
        logic [7:0] d;
        int         low_len;
        int         exp_loads;
        logic [7:0] exp_data;
        int         exp_waits;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{8'h6C, 1'b1, 8'hA5, 6, 1, 8'hA5, 2};
        vecs[1] = '{8'h6D, 1'b1, 8'h11, 6, 0, 8'hA5, 0};
        vecs[2] = '{8'h6C, 1'b0, 8'h22, 6, 0, 8'hA5, 0};
        vecs[3] = '{8'h6C, 1'b1, 8'h3C, 6, 1, 8'h3C, 2};
        vecs[4] = '{8'h6C, 1'b1, 8'h5A, 2, 1, 8'h5A, 2};

        fork monitor_loop(); join_none

        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_state", {load_o[i], rdy_o[i], busy_o[i], data_o[i], cnt_o[i]},
                {1'b0, 1'b1, 1'b0, 8'h00, 8'h00});
        end

        // table-driven bus cycles
        for (int v = 0; v < 5; v++) begin
            clear_counts();
            do_write(vecs[v].a, vecs[v].so, vecs[v].d, vecs[v].low_len, 10);
            chk("tbl_loads_w2", loads[0], vecs[v].exp_loads);
            chk("tbl_loads_w0", loads[1], vecs[v].exp_loads);
            chk("tbl_data_w2", data_o[0], vecs[v].exp_data);
            chk("tbl_data_w0", data_o[1], vecs[v].exp_data);
            chk("tbl_waits_w2", rdylow[0], vecs[v].exp_waits);
            chk("tbl_waits_w0", rdylow[1], 0);
        end
        chk("tbl_count_w2", cnt_o[0], 3);
        chk("tbl_count_w0", cnt_o[1], 3);

        // 256 back-to-back writes wrap wr_count to zero
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        clear_counts();
        for (int k = 0; k < 256; k++) do_write(8'h6C, 1'b1, 8'($urandom), 3, 6);
        repeat (4) @(negedge clock); #1;
        chk("wrap_loads_w2", loads[0], 256);
        chk("wrap_loads_w0", loads[1], 256);
        chk("wrap_count_w2", cnt_o[0], 0);
        chk("wrap_count_w0", cnt_o[1], 0);
        chk("wrap_waits_w2", rdylow[0], 512);

        // reset while in WAIT
        @(negedge clock);
        addr = 8'h6C; dout_bus = 8'h77; s_out = 1'b1;
        @(negedge clock);
        pwr_n = 1'b0;
        begin
            bit seen = 0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clock);
                if (rdy_o[0] == 1'b0) seen = 1;
            end
            chk("rst_wait_reached", seen, 1);
        end
        reset = 1'b1; pwr_n = 1'b1; s_out = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_rdy", rdy_o[0], 1);
        chk("rst_busy", busy_o[0], 0);
        chk("rst_load", load_o[0], 0);
        chk("rst_data", data_o[0], 8'h00);
        for (int i = 0; i < 2; i++) begin loads[i] = 0; rdylow[i] = 0; end
        repeat (10) @(negedge clock); #1;
        chk("rst_no_load_w2", loads[0], 0);
        chk("rst_no_load_w0", loads[1], 0);

        // randomized bus traffic against the model
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clock); reset = 1'b1; pwr_n = 1'b1;
                @(negedge clock); reset = 1'b0;
            end
            do_write(($urandom_range(0, 3) != 0) ? 8'h6C : 8'($urandom),
                     ($urandom_range(0, 4) != 0),
                     8'($urandom),
                     $urandom_range(1, 8), $urandom_range(1, 6));
        end
        repeat (12) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
